// File: rtl/hc_keystream_xor.sv
// Keystream consumer for the HC cipher core: prefetches keystream words into a FIFO
// and XORs them with a valid/ready data stream. Optional macro: HC_KSXOR_WORD_COUNT_EN.
module hc_keystream_xor #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        init,
   output logic        ready,
   output logic        core_init,
   output logic        core_next,
   input  logic        core_ready,
   input  logic [31:0] ks_word,
   input  logic        ks_valid,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
`ifdef HC_KSXOR_WORD_COUNT_EN
   output logic [31:0] word_count,
`endif
   output logic [1:0]  dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FILL_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             core_init_q;
   logic             outstanding_q, outstanding_d;
   logic [PTR_W:0]   fill_q, fill_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      out_data_q;
   logic             out_valid_q;
   logic             run;
   logic             push;
   logic             pop;

   // Valid/ready: a word moves only in a cycle where both valid and ready are high;
   // a producer holds its word stable until then, and ready never looks at valid.
   assign run       = (state_q == ST_RUN);
   assign core_next = run && !outstanding_q && (fill_q < FILL_FULL);
   assign push      = ks_valid && outstanding_q;
   assign in_ready  = run && (fill_q != '0) && (!out_valid_q || out_ready);
   assign pop       = in_valid && in_ready;

   assign ready     = run;
   assign core_init = core_init_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign dbg_state = state_q;

   // core_ready is ignored while core_init is still high so a ready left over
   // from the previous session cannot skip key setup.
   always_comb begin
      state_d = state_q;
      if (init) begin
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_INIT: if (!core_init_q && core_ready) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      fill_d        = fill_q;
      if (init) begin
         outstanding_d = 1'b0;
         fill_d        = '0;
      end else begin
         if (core_next) begin
            outstanding_d = 1'b1;
         end else if (push) begin
            outstanding_d = 1'b0;
         end
         case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         core_init_q   <= 1'b0;
         outstanding_q <= 1'b0;
         fill_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_init_q   <= init;
         outstanding_q <= outstanding_d;
         fill_q        <= fill_d;
         if (init) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
               rd_ptr_q    <= rd_ptr_q + 1'b1;
               out_data_q  <= in_data ^ mem_q[rd_ptr_q];
               out_valid_q <= 1'b1;
            end else if (out_ready) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   // Storage needs no reset: fill_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= ks_word;
   end

`ifdef HC_KSXOR_WORD_COUNT_EN
   logic [31:0] word_count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_count_q <= '0;
      end else if (init) begin
         word_count_q <= '0;
      end else if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
         word_count_q <= word_count_q + 32'd1;
      end
   end

   assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_hc_keystream_xor.sv
// Self-checking bench for hc_keystream_xor: HC core model with 3-cycle latency,
// reference model of keystream order, and an output scoreboard.
module tb_hc_keystream_xor;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        init;
   logic        ready;
   logic        core_init;
   logic        core_next;
   logic        core_ready = 1'b0;
   logic [31:0] ks_word = '0;
   logic        ks_valid = 1'b0;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  dbg_state;
`ifdef HC_KSXOR_WORD_COUNT_EN
   logic [31:0] word_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] ks_model_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] ks_src_q[$];
   int          cn_q[$];
   int          cyc       = 0;
   int          pend      = 0;
   bit          stale     = 1'b0;
   int          rdy_cd    = 0;
   int          rdy_cyc   = -1;
   bit          ready_prev = 1'b0;
   logic [31:0] sb_e;

   always #5 clk = ~clk;

   hc_keystream_xor #(.DEPTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .init       (init),
      .ready      (ready),
      .core_init  (core_init),
      .core_next  (core_next),
      .core_ready (core_ready),
      .ks_word    (ks_word),
      .ks_valid   (ks_valid),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef HC_KSXOR_WORD_COUNT_EN
      .word_count (word_count),
`endif
      .dbg_state  (dbg_state)
   );

   // Core model and reference model, evaluated mid-cycle on settled signals.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (reset_n !== 1'b1) begin
            ks_model_q.delete();
            exp_q.delete();
            pend       = 0;
            stale      = 1'b0;
            ks_valid   = 1'b0;
            ready_prev = 1'b0;
            continue;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected_output got=%h exp=none", out_data);
            end else begin
               sb_e = exp_q.pop_front();
               if (out_data !== sb_e) begin
                  failures++;
                  $display("FAIL sb_out_data got=%h exp=%h", out_data, sb_e);
               end
            end
         end
         if (in_valid && in_ready) begin
            if (ks_model_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_accept_without_keystream got=accepted exp=not_ready");
            end else begin
               exp_q.push_back(in_data ^ ks_model_q.pop_front());
            end
         end
         ks_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               ks_word  = (ks_src_q.size() > 0) ? ks_src_q.pop_front() : $urandom;
               ks_valid = 1'b1;
               if (!stale) ks_model_q.push_back(ks_word);
               stale = 1'b0;
            end
         end
         if (core_next) begin
            cn_q.push_back(cyc);
            if (pend == 0) pend = 3;
         end
         if (ready && !ready_prev) rdy_cyc = cyc;
         ready_prev = ready;
         if (init) begin
            ks_model_q.delete();
            exp_q.delete();
            cn_q.delete();
            if (pend > 0) stale = 1'b1;
            core_ready = 1'b0;
            rdy_cd     = 6;
         end else if (rdy_cd > 0) begin
            rdy_cd--;
            if (rdy_cd == 0) core_ready = 1'b1;
         end
      end
   end

   task automatic cyc_start();
      @(posedge clk);
      #2;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_init();
      cyc_start();
      init     = 1'b1;
      in_valid = 1'b0;
      cyc_start();
      init = 1'b0;
      mid();
      checks++;
      if (core_init !== 1'b1) begin
         failures++;
         $display("FAIL core_init_pulse got=%b exp=1", core_init);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         mid();
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_timeout got=%b exp=1", ready);
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      init      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) cyc_start();
      mid();
      checks++;
      if ({ready, core_init, core_next, in_ready, out_valid} !== 5'b0) begin
         failures++;
         $display("FAIL reset_controls got=%b exp=00000",
                  {ready, core_init, core_next, in_ready, out_valid});
      end
      checks++;
      if (out_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_out_data got=%h exp=00000000", out_data);
      end
      cyc_start();
      reset_n = 1'b1;
      repeat (3) cyc_start();
      mid();
      checks++;
      if (ready !== 1'b0 || core_next !== 1'b0) begin
         failures++;
         $display("FAIL idle_without_init got=%b%b exp=00", ready, core_next);
      end
   endtask

   task automatic test_prefetch();
      ks_src_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      do_init();
      wait_ready();
      repeat (24) cyc_start();
      mid();
      checks++;
      if (cn_q.size() !== 4) begin
         failures++;
         $display("FAIL prefetch_request_count got=%0d exp=4", cn_q.size());
      end else begin
         checks++;
         if (cn_q[0] !== rdy_cyc) begin
            failures++;
            $display("FAIL first_core_next_cycle got=%0d exp=%0d", cn_q[0], rdy_cyc);
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (cn_q[i+1] - cn_q[i] !== 4) begin
               failures++;
               $display("FAIL core_next_spacing got=%0d exp=4", cn_q[i+1] - cn_q[i]);
            end
         end
      end
      checks++;
      if (ready !== 1'b1 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL run_ready_after_fill got=%b%b exp=11", ready, in_ready);
      end
   endtask

   task automatic test_xor_vectors();
      logic [31:0] exp_v[4];
      exp_v = '{32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc_start();
         in_valid = (i < 4);
         in_data  = 32'hFFFF_FFFF;
         mid();
         checks++;
         if (i < 4) begin
            if (in_ready !== 1'b1) begin
               failures++;
               $display("FAIL vec_in_ready idx=%0d got=%b exp=1", i, in_ready);
            end
         end else if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL vec_empty_in_ready got=%b exp=0", in_ready);
         end
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[i-1]) begin
               failures++;
               $display("FAIL vec_out idx=%0d got=%b/%h exp=1/%h", i - 1, out_valid,
                        out_data, exp_v[i-1]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d1;
      logic [31:0] held;
      repeat (20) cyc_start();
      cyc_start();
      d1        = $urandom;
      in_valid  = 1'b1;
      in_data   = d1;
      out_ready = 1'b1;
      held      = (ks_model_q.size() > 0) ? (d1 ^ ks_model_q[0]) : 32'h0;
      mid();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_first_accept got=%b exp=1", in_ready);
      end
      for (int k = 0; k < 3; k++) begin
         cyc_start();
         out_ready = 1'b0;
         in_data   = $urandom;
         mid();
         checks++;
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/%h/0", k, out_valid,
                     out_data, in_ready, held);
         end
      end
      cyc_start();
      out_ready = 1'b1;
      mid();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release got=%b exp=1", in_ready);
      end
      cyc_start();
      in_valid = 1'b0;
      mid();
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_second_output got=%b exp=1", out_valid);
      end
   endtask

   task automatic test_random();
      repeat (300) begin
         cyc_start();
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      cyc_start();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cyc_start();
      mid();
      checks++;
      if (exp_q.size() !== 0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL random_drain got=%0d/%b exp=0/0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_stale_init();
      int n;
      cyc_start();
      in_valid = 1'b1;
      in_data  = $urandom;
      cyc_start();
      in_valid = 1'b0;
      n = 0;
      mid();
      while (core_next !== 1'b1 && n < 20) begin
         mid();
         n++;
      end
      checks++;
      if (core_next !== 1'b1) begin
         failures++;
         $display("FAIL stale_request_timeout got=%b exp=1", core_next);
      end
      do_init();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL init_flush got=%b%b exp=00", out_valid, in_ready);
      end
      cyc_start();
      in_valid = 1'b1;
      in_data  = $urandom;
      wait_ready();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            cyc_start();
            in_data = $urandom;
         end
         if (k > 0) mid();
         checks++;
         if (in_ready !== (k == 4)) begin
            failures++;
            $display("FAIL stale_fill cyc=%0d got=%b exp=%b", k, in_ready, (k == 4));
         end
      end
      cyc_start();
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int n;
      n = 0;
      mid();
      while (ks_model_q.size() != 3 && n < 40) begin
         mid();
         n++;
      end
      checks++;
      if (ks_model_q.size() != 3) begin
         failures++;
         $display("FAIL fill3_timeout got=%0d exp=3", ks_model_q.size());
      end
      cyc_start();
      reset_n = 1'b0;
      mid();
      checks++;
      if ({ready, core_init, core_next, in_ready, out_valid} !== 5'b0 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL midrun_reset got=%b/%h exp=00000/00000000",
                  {ready, core_init, core_next, in_ready, out_valid}, out_data);
      end
      cyc_start();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc_start();
         mid();
         checks++;
         if (ready !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle cyc=%0d got=%b%b exp=00", k, ready, in_ready);
         end
      end
      do_init();
      wait_ready();
   endtask

`ifdef HC_KSXOR_WORD_COUNT_EN
   task automatic test_word_count();
      int hs;
      int n;
      hs = 0;
      n  = 0;
      out_ready = 1'b1;
      repeat (20) cyc_start();
      while (hs < 10 && n < 200) begin
         cyc_start();
         in_valid = 1'b1;
         in_data  = $urandom;
         mid();
         if (in_valid && in_ready) hs++;
         n++;
      end
      cyc_start();
      in_valid = 1'b0;
      mid();
      checks++;
      if (word_count !== 32'd10) begin
         failures++;
         $display("FAIL word_count_10 got=%0d exp=10", word_count);
      end
      do_init();
      checks++;
      if (word_count !== 32'd0) begin
         failures++;
         $display("FAIL word_count_init got=%0d exp=0", word_count);
      end
   endtask
`endif

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      test_reset();
      test_prefetch();
      test_xor_vectors();
      test_backpressure();
      test_random();
      test_stale_init();
      test_reset_mid_run();
`ifdef HC_KSXOR_WORD_COUNT_EN
      test_word_count();
`endif
      repeat (2) cyc_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
